// File: rtl/linear_dac_pkg.sv
// Shared helpers for the linear_dac generator-path calibration stage:
// lane saturation and the Q2.(DWM-2) unity-gain constant.
package linear_dac_pkg;

    localparam int SAT_W = 64;
    typedef logic signed [SAT_W-1:0] wide_t;

    // Unity gain in Q2.(dwm-2) format.
    function automatic int q_one(input int dwm);
        return 1 << (dwm - 2);
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic wide_t sat(input wide_t v, input int w);
        wide_t mx;
        wide_t mn;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn = -(wide_t'(1) <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-stream bundle carrying its own clock and active-low reset.
interface axi4_stream_if #(
    parameter int DN = 1,
    parameter int DW = 14
) (
    input logic ACLK,
    input logic ARESETn
);
    logic [DN-1:0][DW-1:0] TDATA;
    logic [DN-1:0]         TKEEP;
    logic                  TLAST;
    logic                  TVALID;
    logic                  TREADY;

    modport s (input ACLK, ARESETn, TREADY, output TDATA, TKEEP, TLAST, TVALID);
    modport d (input ACLK, ARESETn, TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/linear_dac_sts.sv
// Saturation status: sticky flag plus a counter that holds at all-ones.
// An event in the same cycle as a clear wins and restarts the count at 1.
module linear_dac_sts #(
    parameter int DWC = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic           i_evt,
    output logic           o_ovf,
    output logic [DWC-1:0] o_cnt
);
    logic           r_ovf;
    logic [DWC-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (i_evt) begin
            r_ovf <= 1'b1;
            if (i_clr)
                r_cnt <= DWC'(1);
            else if (r_cnt != '1)
                r_cnt <= r_cnt + DWC'(1);
        end else if (i_clr) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end
    end

    assign o_ovf = r_ovf;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/linear_dac.sv
// Generator-path calibration: subtract offset, apply Q2 gain, floor-shift and
// saturate, as a three-stage AXI4-stream pipeline with full backpressure.
module linear_dac
    import linear_dac_pkg::*;
#(
    parameter int  DN  = 1,
    parameter type DTI = logic signed [14-1:0],
    parameter type DTO = logic signed [14-1:0],
    parameter int  DWI = $bits(DTI),
    parameter int  DWO = $bits(DTO),
    parameter int  DWM = 16,
    parameter int  DWS = DWI,
    parameter int  DWC = 32
) (
    axi4_stream_if.d              sti,
    axi4_stream_if.s              sto,
    input  logic signed [DWM-1:0] cfg_mul,
    input  logic signed [DWS-1:0] cfg_sum,
    input  logic                  cfg_clr,
    output logic                  sts_ovf,
    output logic [DWC-1:0]        sts_cnt
);
    localparam int DD = DWI + 1;
    localparam int DP = DD + DWM;

    logic w_clk;
    logic w_rst_n;
    assign w_clk   = sti.ACLK;
    assign w_rst_n = sti.ARESETn;

    logic                   r_s1_vld, r_s2_vld, r_s3_vld;
    logic [DN-1:0]          r_s1_keep, r_s2_keep, r_s3_keep;
    logic                   r_s1_last, r_s2_last, r_s3_last;
    logic [DN-1:0][DD-1:0]  r_s1_d;
    logic [DN-1:0][DP-1:0]  r_s2_p;
    logic [DN-1:0][DWO-1:0] r_s3_q;

    logic [DN-1:0][DWI-1:0] w_x;
    logic [DN-1:0][DD-1:0]  w_d;
    logic [DN-1:0][DP-1:0]  w_p;
    logic [DN-1:0][DWO-1:0] w_q;
    logic [DN-1:0]          w_hit;
    logic                   w_s1_rdy, w_s2_rdy, w_s3_rdy, w_evt;

    assign w_x = sti.TDATA;

    // A stage accepts when it is empty or its content moves on this cycle.
    assign w_s3_rdy   = sto.TREADY | ~r_s3_vld;
    assign w_s2_rdy   = w_s3_rdy   | ~r_s2_vld;
    assign w_s1_rdy   = w_s2_rdy   | ~r_s1_vld;
    assign sti.TREADY = w_s1_rdy;

    for (genvar g = 0; g < DN; g++) begin : g_lane
        logic signed [DWI-1:0] w_xl;
        logic signed [DD-1:0]  w_dl;
        logic signed [DP-1:0]  w_pl;
        logic signed [DP-1:0]  w_s;
        wide_t                 w_sv;

        assign w_xl     = w_x[g];
        assign w_d[g]   = DD'(w_xl) - DD'(cfg_sum);
        assign w_dl     = r_s1_d[g];
        assign w_p[g]   = DP'(w_dl) * DP'(cfg_mul);
        assign w_pl     = r_s2_p[g];
        assign w_s      = w_pl >>> (DWM - 2);
        assign w_sv     = sat(wide_t'(w_s), DWO);
        assign w_q[g]   = w_sv[DWO-1:0];
        // Kept-out lanes still compute but never count as a saturation.
        assign w_hit[g] = (w_sv != wide_t'(w_s)) & r_s2_keep[g];
    end

    assign w_evt = r_s2_vld & w_s3_rdy & (|w_hit);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_s1_keep <= '0;
            r_s2_keep <= '0;
            r_s3_keep <= '0;
            r_s1_last <= 1'b0;
            r_s2_last <= 1'b0;
            r_s3_last <= 1'b0;
            r_s1_d    <= '0;
            r_s2_p    <= '0;
            r_s3_q    <= '0;
        end else begin
            if (w_s1_rdy) r_s1_vld <= sti.TVALID;
            if (sti.TVALID & w_s1_rdy) begin
                r_s1_d    <= w_d;
                r_s1_keep <= sti.TKEEP;
                r_s1_last <= sti.TLAST;
            end
            if (w_s2_rdy) r_s2_vld <= r_s1_vld;
            if (r_s1_vld & w_s2_rdy) begin
                r_s2_p    <= w_p;
                r_s2_keep <= r_s1_keep;
                r_s2_last <= r_s1_last;
            end
            if (w_s3_rdy) r_s3_vld <= r_s2_vld;
            if (r_s2_vld & w_s3_rdy) begin
                r_s3_q    <= w_q;
                r_s3_keep <= r_s2_keep;
                r_s3_last <= r_s2_last;
            end
        end
    end

    assign sto.TVALID = r_s3_vld;
    assign sto.TDATA  = r_s3_q;
    assign sto.TKEEP  = r_s3_keep;
    assign sto.TLAST  = r_s3_last;

    linear_dac_sts #(.DWC(DWC)) u_sts (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_clr   (cfg_clr),
        .i_evt   (w_evt),
        .o_ovf   (sts_ovf),
        .o_cnt   (sts_cnt)
    );

endmodule

// File: tb/tb_linear_dac.sv
// Scoreboard bench for linear_dac: directed beats push expected results,
// an independent monitor pops and compares every output transfer.
module tb_linear_dac;
    import linear_dac_pkg::*;

    localparam int DWC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if #(.DN(1), .DW(14)) sti_if (.ACLK(clk), .ARESETn(rst_n));
    axi4_stream_if #(.DN(1), .DW(14)) sto_if (.ACLK(clk), .ARESETn(rst_n));

    logic signed [15:0] cfg_mul;
    logic signed [13:0] cfg_sum;
    logic               cfg_clr;
    logic               sts_ovf;
    logic [DWC-1:0]     sts_cnt;

    linear_dac #(.DWC(DWC)) dut (
        .sti     (sti_if),
        .sto     (sto_if),
        .cfg_mul (cfg_mul),
        .cfg_sum (cfg_sum),
        .cfg_clr (cfg_clr),
        .sts_ovf (sts_ovf),
        .sts_cnt (sts_cnt)
    );

    typedef struct {
        int data;
        bit last;
        bit lat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Called at a negedge; returns at a later negedge with TVALID dropped.
    task automatic send(input int x, input int req, input bit last, input bit keep, input bit lat);
        exp_t e;
        int   n;
        n = 0;
        sti_if.TVALID = 1'b1;
        sti_if.TDATA  = 14'(x);
        sti_if.TLAST  = last;
        sti_if.TKEEP  = keep;
        #1;
        while (!sti_if.TREADY && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!sti_if.TREADY) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: x=%0d got sti.TREADY=0, expected 1", x);
        end else begin
            e.data = req;
            e.last = last;
            e.lat  = lat;
            e.cyc  = cyc;
            q.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        sti_if.TVALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || sto_if.TVALID) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats, expected 0", q.size());
        end
    endtask

    task automatic clear();
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
    endtask

    // Monitor: compare every output transfer against the head of the queue.
    initial begin : mon
        logic signed [13:0] v;
        exp_t               e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && sto_if.TVALID && sto_if.TREADY) begin
                v = sto_if.TDATA[0];
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0d, expected no beat", v);
                end else begin
                    e = q.pop_front();
                    chk("data", v, e.data);
                    chk("last", sto_if.TLAST, e.last);
                    if (e.lat) chk("latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        sti_if.TVALID = 1'b0;
        sti_if.TDATA  = '0;
        sti_if.TKEEP  = '0;
        sti_if.TLAST  = 1'b0;
        sto_if.TREADY = 1'b1;
        cfg_mul       = 16'(q_one(16));
        cfg_sum       = '0;
        cfg_clr       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", sto_if.TVALID, 0);
        chk("rst_tdata", sto_if.TDATA, 0);
        chk("rst_tkeep", sto_if.TKEEP, 0);
        chk("rst_tlast", sto_if.TLAST, 0);
        chk("rst_ovf", sts_ovf, 0);
        chk("rst_cnt", sts_cnt, 0);
        chk("rst_sti_ready", sti_if.TREADY, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Unity gain, plus a plain negative value.
        send(1000, 1000, 1'b0, 1'b1, 1'b1);
        drain();
        send(-5, -5, 1'b1, 1'b1, 1'b1);
        drain();
        chk("unity_cnt", sts_cnt, 0);
        chk("unity_ovf", sts_ovf, 0);

        // Offset removal, then an offset that pushes past full scale.
        cfg_sum = 14'sd100;
        send(1100, 1000, 1'b0, 1'b1, 1'b0);
        drain();
        cfg_sum = -14'sd8192;
        send(8191, 8191, 1'b0, 1'b1, 1'b0);
        drain();
        chk("offs_cnt", sts_cnt, 1);
        chk("offs_ovf", sts_ovf, 1);
        send(8191, 8191, 1'b0, 1'b0, 1'b0);
        drain();
        chk("nokeep_cnt", sts_cnt, 1);

        // Half gain exposes floor rounding: -1.5 -> -2, 1.5 -> 1.
        cfg_sum = '0;
        cfg_mul = 16'sd8192;
        send(-3, -2, 1'b0, 1'b1, 1'b0);
        send(3, 1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("floor_cnt", sts_cnt, 1);

        // Positive and negative clip.
        clear();
        chk("clr_cnt", sts_cnt, 0);
        chk("clr_ovf", sts_ovf, 0);
        cfg_mul = 16'sd32767;
        send(8000, 8191, 1'b0, 1'b1, 1'b0);
        send(-8192, -8192, 1'b0, 1'b1, 1'b0);
        drain();
        chk("clip_cnt", sts_cnt, 2);
        chk("clip_ovf", sts_ovf, 1);
        cfg_mul = -16'sd32768;
        send(-4096, 8191, 1'b0, 1'b1, 1'b0);
        drain();
        chk("negmul_cnt", sts_cnt, 3);

        // Backpressure: output stalled for 5 cycles while a stream arrives.
        cfg_mul = 16'(q_one(16));
        n_acc   = 0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send(i, i, (i % 4) == 0, 1'b1, 1'b0);
            end
            begin
                sto_if.TREADY = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                chk("bp_accepted", n_acc, 3);
                chk("bp_sti_ready", sti_if.TREADY, 0);
                @(negedge clk);
                sto_if.TREADY = 1'b1;
            end
        join
        drain();
        chk("bp_total", n_acc, 12);
        chk("bp_cnt", sts_cnt, 3);

        // Clear coinciding with a saturating S3 load.
        cfg_sum = -14'sd8192;
        send(8191, 8191, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_clr = 1'b0;
        chk("clr_evt_cnt", sts_cnt, 1);
        chk("clr_evt_ovf", sts_ovf, 1);
        drain();
        clear();
        chk("clr_alone_cnt", sts_cnt, 0);
        chk("clr_alone_ovf", sts_ovf, 0);

        // Drive the counter to all-ones, then one more event must hold it.
        for (int i = 0; i < 15; i++) send(8191, 8191, 1'b0, 1'b1, 1'b0);
        drain();
        chk("cnt_full", sts_cnt, 15);
        send(8191, 8191, 1'b0, 1'b1, 1'b0);
        drain();
        chk("cnt_hold", sts_cnt, 15);
        chk("cnt_hold_ovf", sts_ovf, 1);

        // Asynchronous reset with three beats in flight.
        clear();
        sto_if.TREADY = 1'b0;
        for (int i = 0; i < 3; i++) send(8191, 8191, 1'b0, 1'b1, 1'b0);
        chk("inflight_valid", sto_if.TVALID, 1);
        chk("inflight_cnt", sts_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", sto_if.TVALID, 0);
        chk("arst_cnt", sts_cnt, 0);
        chk("arst_ovf", sts_ovf, 0);
        q.delete();
        @(negedge clk);
        rst_n         = 1'b1;
        sto_if.TREADY = 1'b1;
        cfg_sum       = '0;
        send(1234, 1234, 1'b1, 1'b1, 1'b1);
        drain();
        chk("post_rst_cnt", sts_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
